input_conditioner: RTL
======================

# input_conditioner

N-channel input front end that replaces the per-bit synchroniser and debounce instances at the top of `soc` with one parametrised block. Every channel gets a metastability chain, a counter-based debouncer driven by a shared sample-tick prescaler, and one-cycle rise/fall pulses. An optional sticky event register lets software-style polling logic catch button presses shorter than its poll period. It sits between the board pins (switches, push buttons) and the `cpu`/`enable_gen` inputs.

## Interface

Parameters:
- N, 8, number of channels
- SYNC_STAGES, 2, synchroniser flops per channel (min 2)
- CLK_PERIOD_ns, 20, clock period
- DEBOUNCE_TIMER_ns, 30_000_000, required stable time
- SAMPLE_DIV, 1000, clocks per sample tick
- RESET_VALUE, {N{1'b0}}, level of sync chain and `sig_o` in reset

DEBOUNCE_SAMPLES = DEBOUNCE_TIMER_ns / (CLK_PERIOD_ns * SAMPLE_DIV), a derived localparam. It must be at least 1; a value below 1 is an elaboration error.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous assert, active-low
- enable  in  1  freezes prescaler and counters when low
- sig_i  in  N  raw asynchronous inputs
- clear_i  in  N  per-channel event clear mask (sticky mode only)
- sig_o  out  N  debounced levels
- rise_o  out  N  one-cycle pulse on debounced 0->1
- fall_o  out  N  one-cycle pulse on debounced 1->0
- event_o  out  N  sticky rise flags

## Operation

**Reset** (resetn low, any time, including mid-count): all outputs and internal state take their reset values immediately.
- Sync chain = RESET_VALUE; sig_o = RESET_VALUE.
- rise_o, fall_o, event_o = 0.
- Prescaler and all counters = 0.

**Prescaler**
- Free-runs 0..SAMPLE_DIV-1 while enable=1.
- `tick` is asserted for the one cycle in which the count equals SAMPLE_DIV-1, after which the count wraps to 0.

**Per channel**
- `s` is the output of the last sync stage.
- If s == sig_o: the counter clears to 0 on that cycle, whether or not a tick occurs. This discards glitches.
- If s != sig_o and tick occurs:
  - counter < DEBOUNCE_SAMPLES-1: counter increments.
  - counter == DEBOUNCE_SAMPLES-1: sig_o <= s, counter <= 0, and rise_o or fall_o pulses for exactly one cycle, per the direction of the change.
- enable=0: prescaler and counters hold. The sync chain keeps sampling, and the equal-level counter clear still applies.
- Counter width is clog2(DEBOUNCE_SAMPLES). The counter never exceeds DEBOUNCE_SAMPLES-1.

**Sticky events** (see Configuration)
- event_o[k] is set in the cycle rise_o[k] is 1.
- event_o[k] is cleared in the cycle clear_i[k] is 1.
- If set and clear occur in the same cycle, set wins.

## Timing

- Sync latency: SYNC_STAGES cycles from sig_i to s.
- Debounce latency: sig_o updates N_d cycles after s first mismatches, where (DEBOUNCE_SAMPLES-1)*SAMPLE_DIV+1 ≤ N_d ≤ DEBOUNCE_SAMPLES*SAMPLE_DIV. This holds only if s stays stable throughout and enable=1.
- rise_o and fall_o are registered and coincide with the sig_o update cycle.
- event_o is visible one cycle after the rise_o cycle.
- First tick after reset release: cycle SAMPLE_DIV-1 (0-based). Ticks then repeat every SAMPLE_DIV cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- Macro: INPUT_CONDITIONER_STICKY_EN.
- Defined: event register built as described in Operation.
- Undefined: event_o is tied to 0, clear_i is unused, and no event flops are built.

## Structure

Shared package `soc_io_pkg` holds:
- the clog2 function;
- default timing constants (CLK_PERIOD_NS = 20, DEBOUNCE_NS = 30_000_000, SAMPLE_DIV = 1000), also used by `enable_gen`.

Sub-module `debounce_channel` is one channel: sync chain, counter, edge pulses, event flop. It is instantiated N times by a generate loop indexed by its own genvar. The prescaler stays in the top level and broadcasts `tick`.

## Test plan

Bench parameters for all scenarios: CLK_PERIOD_ns=20, DEBOUNCE_TIMER_ns=400, SAMPLE_DIV=4, which gives DEBOUNCE_SAMPLES=5.

1. Reset with sig_i=8'hA5 and RESET_VALUE=0, then release → sig_o=0 and no rise_o during reset. sig_o reaches 8'hA5 within SYNC_STAGES+20 cycles, and rise_o pulses exactly once on bits 0, 2, 5 and 7.
2. Channel 3 glitch high for 12 cycles, then low → sig_o[3] stays 0; no rise_o or fall_o.
3. Channel 0 step 0->1, held 40 cycles, then 1->0 → one rise_o[0] pulse, then one fall_o[0] pulse. Each edge lands 17..20 cycles after s changes.
4. enable=0 for 50 cycles mid-count on channel 1 → sig_o[1] frozen; the count resumes after enable returns and completes the remaining ticks.
5. Sticky mode: rise on channel 2 with clear_i[2]=1 asserted in the same cycle as rise_o[2] → event_o[2]=1. A later clear_i[2] pulse → event_o[2]=0 on the next cycle.
6. Assert resetn low while channel 4 is mid-count (counter=3) → immediate reset values; after release a fresh 5-tick count is required.

Source files
------------

// File: rtl/soc_io_pkg.sv
// Shared I/O constants and helpers for the pin front end and enable_gen.
package soc_io_pkg;

  localparam int CLK_PERIOD_NS = 20;
  localparam int DEBOUNCE_NS   = 30_000_000;
  localparam int SAMPLE_DIV    = 1000;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: sync chain, tick-driven debounce counter, edge pulses.
// The sticky event flop exists only when INPUT_CONDITIONER_STICKY_EN is defined.
module debounce_channel
  import soc_io_pkg::*;
#(
  parameter int   SYNC_STAGES      = 2,
  parameter int   DEBOUNCE_SAMPLES = 1,
  parameter logic RESET_VALUE      = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_tick,
  input  logic i_sig,
  input  logic i_clear,
  output logic o_sig,
  output logic o_rise,
  output logic o_fall,
  output logic o_event
);

  localparam int CNT_W = (clog2(DEBOUNCE_SAMPLES) < 1) ? 1 : clog2(DEBOUNCE_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SAMPLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sig;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_sync <= {SYNC_STAGES{RESET_VALUE}};
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
  end

  // Any cycle where the synced level agrees with the output restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_sig  <= RESET_VALUE;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_sig) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == CNT_LAST) begin
          r_sig  <= w_s;
          r_cnt  <= '0;
          r_rise <= w_s;
          r_fall <= ~w_s;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_sig  = r_sig;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

`ifdef INPUT_CONDITIONER_STICKY_EN
  logic r_event;

  // Set has priority so a press is never lost to a coincident clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      r_event <= 1'b0;
    else if (r_rise)  r_event <= 1'b1;
    else if (i_clear) r_event <= 1'b0;
  end

  assign o_event = r_event;
`else
  logic w_unused_clear;
  assign w_unused_clear = i_clear;
  assign o_event        = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// N-channel pin front end: shared sample-tick prescaler feeding per-channel debouncers.
// Define INPUT_CONDITIONER_STICKY_EN to build the sticky rise-event register.
module input_conditioner
  import soc_io_pkg::*;
#(
  parameter int           N                 = 8,
  parameter int           SYNC_STAGES       = 2,
  parameter int           CLK_PERIOD_ns     = soc_io_pkg::CLK_PERIOD_NS,
  parameter int           DEBOUNCE_TIMER_ns = soc_io_pkg::DEBOUNCE_NS,
  parameter int           SAMPLE_DIV        = soc_io_pkg::SAMPLE_DIV,
  parameter logic [N-1:0] RESET_VALUE       = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable,
  input  logic [N-1:0] sig_i,
  input  logic [N-1:0] clear_i,
  output logic [N-1:0] sig_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o,
  output logic [N-1:0] event_o
);

  localparam int DEBOUNCE_SAMPLES = DEBOUNCE_TIMER_ns / (CLK_PERIOD_ns * SAMPLE_DIV);
  localparam int PRE_W = (clog2(SAMPLE_DIV) < 1) ? 1 : clog2(SAMPLE_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SAMPLE_DIV - 1);

  if (DEBOUNCE_SAMPLES < 1) begin : g_bad_samples
    $error("input_conditioner: DEBOUNCE_SAMPLES must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES must be at least 2");
  end
  if (SAMPLE_DIV < 1) begin : g_bad_div
    $error("input_conditioner: SAMPLE_DIV must be at least 1");
  end

  logic [PRE_W-1:0] r_presc;
  logic             w_tick;

  assign w_tick = enable && (r_presc == PRE_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     r_presc <= '0;
    else if (enable) r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
  end

  genvar g_ch;
  for (g_ch = 0; g_ch < N; g_ch++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES      (SYNC_STAGES),
      .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
      .RESET_VALUE      (RESET_VALUE[g_ch])
    ) u_chan (
      .clk     (clk),
      .resetn  (resetn),
      .i_tick  (w_tick),
      .i_sig   (sig_i[g_ch]),
      .i_clear (clear_i[g_ch]),
      .o_sig   (sig_o[g_ch]),
      .o_rise  (rise_o[g_ch]),
      .o_fall  (fall_o[g_ch]),
      .o_event (event_o[g_ch])
    );
  end

endmodule
